// File: rtl/img_loader_if.sv
// Host register bus and pixel-write bus of the image loader.
// master: host/bench side; slave: the img_loader itself.
interface img_loader_if #(
  parameter int ADDR_W = 16
);
  logic              avs_write;
  logic              avs_read;
  logic [1:0]        avs_address;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [7:0]        cfg_data;
  logic              load_done;
  logic              busy;

  modport master (
    output avs_write,
    output avs_read,
    output avs_address,
    output avs_writedata,
    input  avs_readdata,
    input  avs_waitrequest,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_data,
    input  load_done,
    input  busy
  );

  modport slave (
    input  avs_write,
    input  avs_read,
    input  avs_address,
    input  avs_writedata,
    output avs_readdata,
    output avs_waitrequest,
    output cfg_we,
    output cfg_addr,
    output cfg_data,
    output load_done,
    output busy
  );
endinterface

// File: rtl/img_loader.sv
// Image loader: host writes packed 4-pixel words, which are queued
// and unpacked into one pixel write per cycle at BASE+count.
// Ports: clk, rst (async, active-high), bus (img_loader_if.slave):
//   avs_* host register port, cfg_* pixel write port,
//   load_done, busy status.
// Optional: define IMG_LOADER_CHECKSUM_EN for a 16-bit pixel checksum
// readable at register 2 (reads 0 otherwise).
module img_loader #(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input logic       clk,
  input logic       rst,
  img_loader_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int TOTAL_I = IMG_W * IMG_H;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_I - 1);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    DONE
  } state_t;

  state_t            state;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fill;
  logic [31:0]       word;
  logic [1:0]        k;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  count;
  logic [31:0]       ovf;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              done_q;
  logic [31:0]       rdata_q;
  logic [31:0]       csum_rd;

  logic fifo_full;
  logic fifo_empty;
  logic data_wr;
  logic base_wr;
  logic restart;
  logic push;
  logic pop;
  logic last;
  logic flush;
  logic [7:0] cur_byte;

  assign fifo_full  = (fill == DEPTH);
  assign fifo_empty = (fill == '0);

  assign data_wr = bus.avs_write && (bus.avs_address == 2'd2);
  assign base_wr = bus.avs_write && (bus.avs_address == 2'd1);
  assign restart = bus.avs_write && (bus.avs_address == 2'd0)
                && bus.avs_writedata[0];

  // Stall depends only on the registered fill level, so a pop in the
  // same cycle never releases the host early.
  assign bus.avs_waitrequest = data_wr && fifo_full;

  assign push = data_wr && !fifo_full && (state != DONE) && !restart;
  assign last = (count == LAST_IDX);
  assign cur_byte = word[{k, 3'b000} +: 8];

  // Pop on IDLE with data, or chain the next word after byte 3 unless
  // that byte completes the image.
  assign pop = !restart && !fifo_empty
            && ((state == IDLE)
             || ((state == UNPACK) && (k == 2'd3) && !last));

  // Leftover words are dropped when the image completes.
  assign flush = restart || ((state == UNPACK) && last);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= bus.avs_writedata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fill <= fill + (PTR_W + 1)'(1);
        2'b01:   fill <= fill - (PTR_W + 1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      word   <= '0;
      k      <= '0;
      base   <= '0;
      count  <= '0;
      ovf    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (base_wr) begin
        base <= bus.avs_writedata[ADDR_W-1:0];
      end
      if (restart) begin
        state  <= IDLE;
        k      <= '0;
        count  <= '0;
        ovf    <= '0;
        done_q <= 1'b0;
      end else begin
        if (data_wr && (state == DONE) && (ovf != '1)) begin
          ovf <= ovf + 32'd1;
        end
        unique case (state)
          IDLE: begin
            if (pop) begin
              word  <= mem[rd_ptr];
              k     <= '0;
              state <= UNPACK;
            end
          end
          UNPACK: begin
            we_q   <= 1'b1;
            addr_q <= base + count[ADDR_W-1:0];
            data_q <= cur_byte;
            count  <= count + CNT_W'(1);
            if (last) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (k == 2'd3) begin
              if (pop) begin
                word <= mem[rd_ptr];
                k    <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              k <= k + 2'd1;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef IMG_LOADER_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (restart) begin
      csum <= '0;
    end else if (state == UNPACK) begin
      csum <= csum + {8'd0, cur_byte};
    end
  end

  assign csum_rd = {16'd0, csum};
`else
  assign csum_rd = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (bus.avs_read) begin
      unique case (bus.avs_address)
        2'd0:    rdata_q <= {29'd0, fifo_full, bus.busy, done_q};
        2'd1:    rdata_q <= 32'(count);
        2'd2:    rdata_q <= csum_rd;
        default: rdata_q <= ovf;
      endcase
    end
  end

  assign bus.busy         = !fifo_empty || (state == UNPACK);
  assign bus.cfg_we       = we_q;
  assign bus.cfg_addr     = addr_q;
  assign bus.cfg_data     = data_q;
  assign bus.load_done    = done_q;
  assign bus.avs_readdata = rdata_q;

endmodule

// File: tb/tb_img_loader.sv
// Bench for img_loader: 8x4 image, 4-deep FIFO, directed cases plus
// randomized word streams checked against a pixel-list model.
module tb_img_loader;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int TOTAL = IMG_W * IMG_H;

  logic clk;
  logic rst;

  img_loader_if #(.ADDR_W(16)) bus ();

  img_loader #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .FIFO_DEPTH(4),
    .ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int px_seen;
  bit stall_seen;

  logic [23:0] exp_q[$];
  logic [15:0] m_base;
  int          m_sched;
  int          m_ovf;
  logic [15:0] m_csum;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_csum();
`ifdef IMG_LOADER_CHECKSUM_EN
    return {16'd0, m_csum};
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_sched = 0;
    m_ovf   = 0;
    m_csum  = '0;
  endtask

  task automatic model_accept(input logic [1:0] a, input logic [31:0] d);
    logic [7:0] b;
    case (a)
      2'd0: if (d[0]) model_clear();
      2'd1: m_base = d[15:0];
      2'd2: begin
        if (m_sched >= TOTAL) begin
          m_ovf++;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (m_sched < TOTAL) begin
              b = d[8*i +: 8];
              exp_q.push_back({m_base + 16'(m_sched), b});
              m_csum = m_csum + {8'd0, b};
              m_sched++;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst && bus.cfg_we) begin
      px_seen++;
      if (exp_q.size() == 0) begin
        chk("unexp_we", 32'(bus.cfg_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pix_addr", 32'(bus.cfg_addr), 32'(e[23:8]));
        chk("pix_data", 32'(bus.cfg_data), 32'(e[7:0]));
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
    logic st;
    int n;
    n = 0;
    st = 1'b0;
    bus.avs_write     = 1'b1;
    bus.avs_address   = a;
    bus.avs_writedata = d;
    forever begin
      #1 st = bus.avs_waitrequest;
      @(posedge clk);
      if (!st) break;
      stall_seen = 1'b1;
      n++;
      if (n > 64) begin
        chk("stall_to", 32'(st), 32'd0);
        break;
      end
      @(negedge clk);
    end
    if (!st) model_accept(a, d);
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] v);
    bus.avs_read    = 1'b1;
    bus.avs_address = a;
    @(posedge clk);
    @(negedge clk);
    v = bus.avs_readdata;
    bus.avs_read = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("drain_to", 32'(exp_q.size()) | 32'(bus.busy), 32'd0);
    end
    cycle(2);
  endtask

  task automatic restart();
    avs_wr(2'd0, 32'd1);
  endtask

  logic [31:0] v;
  logic [31:0] w;
  int g;
  int nw;
  int px0;

  initial begin
    n_chk = 0;
    n_err = 0;
    px_seen = 0;
    stall_seen = 1'b0;
    m_base = '0;
    model_clear();
    rst = 1'b1;
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    bus.avs_address   = '0;
    bus.avs_writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(bus.cfg_we), 32'd0);
    chk("rst_addr", 32'(bus.cfg_addr), 32'd0);
    chk("rst_data", 32'(bus.cfg_data), 32'd0);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdata", bus.avs_readdata, 32'd0);
    rst = 1'b0;
    cycle(1);
    avs_rd(2'd0, v);
    chk("rst_status", v, 32'd0);
    avs_rd(2'd1, v);
    chk("rst_count", v, 32'd0);

    // Single word: latency of two edges, then four back-to-back pixels.
    avs_wr(2'd2, 32'h4433_2211);
    chk("lat_n0", 32'(bus.cfg_we), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      cycle(1);
      chk($sformatf("lat_n%0d", i), 32'(bus.cfg_we),
          (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
    end
    drain();
    avs_rd(2'd1, v);
    chk("t1_count", v, 32'd4);
    cycle(2);
    chk("rd_hold", bus.avs_readdata, 32'd4);

    // Six back-to-back words must stall without losing data.
    restart();
    avs_wr(2'd1, 32'h0000_0100);
    stall_seen = 1'b0;
    for (int i = 0; i < 6; i++) avs_wr(2'd2, $urandom);
    chk("t2_stall", 32'(stall_seen), 32'd1);
    drain();
    avs_rd(2'd1, v);
    chk("t2_count", v, 32'd24);

    // Restart while the second byte is on the pixel port.
    restart();
    avs_wr(2'd1, 32'h0000_0040);
    px0 = px_seen;
    avs_wr(2'd2, $urandom);
    cycle(3);
    chk("t3_we_b1", 32'(bus.cfg_we), 32'd1);
    restart();
    chk("t3_we_off", 32'(bus.cfg_we), 32'd0);
    chk("t3_px", 32'(px_seen - px0), 32'd2);
    avs_rd(2'd1, v);
    chk("t3_count", v, 32'd0);
    avs_rd(2'd0, v);
    chk("t3_status", v, 32'd0);
    avs_wr(2'd2, $urandom);
    drain();
    avs_rd(2'd1, v);
    chk("t3_count2", v, 32'd4);

    // Checksum of two all-ones words.
    restart();
    avs_wr(2'd2, 32'hFFFF_FFFF);
    avs_wr(2'd2, 32'hFFFF_FFFF);
    drain();
    avs_rd(2'd2, v);
`ifdef IMG_LOADER_CHECKSUM_EN
    chk("t4_csum", v, 32'h0000_07F8);
`else
    chk("t4_csum", v, 32'd0);
`endif

    // Fill the whole image, then one more word overflows.
    restart();
    avs_wr(2'd1, 32'($urandom_range(0, 65535)));
    for (int i = 0; i < TOTAL / 4; i++) avs_wr(2'd2, $urandom);
    drain();
    chk("t5_done", 32'(bus.load_done), 32'd1);
    avs_wr(2'd2, $urandom);
    cycle(3);
    avs_rd(2'd0, v);
    chk("t5_status", v, 32'h1);
    avs_rd(2'd3, v);
    chk("t5_ovf", v, 32'(m_ovf));
    chk("t5_ovf1", v, 32'd1);
    avs_rd(2'd1, v);
    chk("t5_count", v, 32'(TOTAL));
    avs_rd(2'd2, v);
    chk("t5_csum", v, exp_csum());

    // Random streams, first one straddling the address wrap.
    for (int it = 0; it < 8; it++) begin
      restart();
      w = (it == 0) ? 32'h0000_FFFE : 32'($urandom_range(0, 65535));
      avs_wr(2'd1, w);
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
        g = $urandom_range(0, 2);
        cycle(g);
        avs_wr(2'd2, $urandom);
      end
      drain();
      avs_rd(2'd1, v);
      chk("rnd_count", v, 32'(m_sched));
      avs_rd(2'd2, v);
      chk("rnd_csum", v, exp_csum());
      avs_rd(2'd3, v);
      chk("rnd_ovf", v, 32'(m_ovf));
      avs_rd(2'd0, v);
      chk("rnd_status", v, 32'd0);
    end

    // Asynchronous reset in the middle of a word.
    restart();
    avs_wr(2'd2, $urandom);
    cycle(2);
    chk("t7_we_pre", 32'(bus.cfg_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_we_rst", 32'(bus.cfg_we), 32'd0);
    chk("t7_busy", 32'(bus.busy), 32'd0);
    m_base = '0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    px0 = px_seen;
    cycle(6);
    chk("t7_px", 32'(px_seen - px0), 32'd0);
    avs_rd(2'd1, v);
    chk("t7_count", v, 32'd0);

    chk("end_q", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

endmodule
